// File: rtl/game_tick_scheduler_pkg.sv
// Shared types and constants for the Pong
// game-tick scheduler and its submodules.
package pong_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PAD   = 2'd1,
    S_BALL  = 2'd2,
    S_SCORE = 2'd3
  } state_e;

  localparam int TICK_COUNT_DEF = 1_000_000;
  localparam int FRAME_W        = 8;
  localparam int WD_W           = 8;
  localparam int DIV_W          = 4;

  function automatic logic [DIV_W-1:0] div_next(
    input logic [DIV_W-1:0] cur,
    input logic [DIV_W-1:0] last
  );
    return (cur == last) ? '0 : cur + DIV_W'(1);
  endfunction

endpackage

// File: rtl/game_tick_scheduler_if.sv
// Start/done handshakes between the scheduler
// and the paddle, ball and score blocks.
interface game_tick_scheduler_if;

  logic pad_start;
  logic pad_done;
  logic ball_start;
  logic ball_done;
  logic score_start;
  logic score_done;

  modport master (
    output pad_start, ball_start, score_start,
    input  pad_done,  ball_done,  score_done
  );

  modport slave (
    input  pad_start, ball_start, score_start,
    output pad_done,  ball_done,  score_done
  );

endinterface

// File: rtl/game_tick_scheduler_prescaler.sv
// Game-tick prescaler: wraps every TICK_COUNT
// enabled cycles and flags the last count.
module tick_prescaler #(
  parameter int TICK_COUNT = 10,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_COUNT - 1);

  logic [CNT_W-1:0] cnt_q;

  assign tick_o = en_i && (cnt_q == LAST);

  // Free-running count, held while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= tick_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_tick_scheduler.sv
// Frame sequencer: per game tick runs paddle,
// optional ball, then score update handshakes.
module game_tick_scheduler
  import pong_pkg::*;
#(
  parameter int TICK_COUNT = TICK_COUNT_DEF,
  parameter int CNT_W      = 20,
  parameter int BALL_DIV   = 2,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pause,
  input  logic               clr_err,
  output logic               tick,
  output logic               busy,
  output logic [FRAME_W-1:0] frame_cnt,
  output logic               overrun,
  output logic               timeout_err,
  game_tick_scheduler_if.master bus
);

  localparam logic [WD_W-1:0]  TO_LIM   = WD_W'(TIMEOUT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BALL_DIV - 1);

  state_e             state_q;
  logic [DIV_W-1:0]   div_q;
  logic [WD_W-1:0]    wd_q;
  logic [FRAME_W-1:0] frame_q;
  logic               pad_q;
  logic               ball_q;
  logic               score_q;
  logic               ovr_q;
  logic               to_q;

  logic               done_w;
  logic [WD_W-1:0]    wd_d;
  logic [DIV_W-1:0]   div_d;
  logic               to_hit;
  logic               ovr_set;

  tick_prescaler #(
    .TICK_COUNT (TICK_COUNT),
    .CNT_W      (CNT_W)
  ) u_pre (
    .clk    (clk),
    .rst_n  (reset),
    .en_i   (~pause),
    .tick_o (tick)
  );

  assign busy            = (state_q != S_IDLE);
  assign frame_cnt       = frame_q;
  assign overrun         = ovr_q;
  assign timeout_err     = to_q;
  assign bus.pad_start   = pad_q;
  assign bus.ball_start  = ball_q;
  assign bus.score_start = score_q;

  // Select the done that matters in the current wait state
  always_comb begin
    done_w = 1'b0;
    unique case (1'b1)
      (state_q == S_PAD):   done_w = bus.pad_done;
      (state_q == S_BALL):  done_w = bus.ball_done;
      (state_q == S_SCORE): done_w = bus.score_done;
      default:              done_w = 1'b0;
    endcase
  end

  assign wd_d    = wd_q + WD_W'(1);
  assign div_d   = div_next(div_q, DIV_LAST);
  assign to_hit  = busy && !done_w && (wd_d == TO_LIM);
  assign ovr_set = tick && busy;

  // Sequencer FSM with watchdog and registered start pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      wd_q    <= '0;
      frame_q <= '0;
      pad_q   <= 1'b0;
      ball_q  <= 1'b0;
      score_q <= 1'b0;
    end else begin
      pad_q   <= 1'b0;
      ball_q  <= 1'b0;
      score_q <= 1'b0;
      wd_q    <= wd_d;
      unique case (state_q)
        S_IDLE: begin
          wd_q <= '0;
          if (tick) begin
            state_q <= S_PAD;
            pad_q   <= 1'b1;
          end
        end
        S_PAD: begin
          if (done_w) begin
            wd_q  <= '0;
            div_q <= div_d;
            if (div_q == '0) begin
              state_q <= S_BALL;
              ball_q  <= 1'b1;
            end else begin
              state_q <= S_SCORE;
              score_q <= 1'b1;
            end
          end
        end
        S_BALL: begin
          if (done_w) begin
            wd_q    <= '0;
            state_q <= S_SCORE;
            score_q <= 1'b1;
          end
        end
        S_SCORE: begin
          if (done_w) begin
            wd_q    <= '0;
            state_q <= S_IDLE;
            frame_q <= frame_q + FRAME_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (to_hit) begin
        state_q <= S_IDLE;
        wd_q    <= '0;
      end
    end
  end

  // Sticky error flags; a set event beats a clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovr_q <= 1'b0;
      to_q  <= 1'b0;
    end else begin
      if (ovr_set)      ovr_q <= 1'b1;
      else if (clr_err) ovr_q <= 1'b0;
      if (to_hit)       to_q  <= 1'b1;
      else if (clr_err) to_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler
// with TICK_COUNT=10, BALL_DIV=2, TIMEOUT=8.
module tb_game_tick_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       pause;
  logic       clr_err;
  logic       tick;
  logic       busy;
  logic [7:0] frame_cnt;
  logic       overrun;
  logic       timeout_err;

  int n_pass = 0;
  int n_tot  = 0;
  int k      = 0;

  game_tick_scheduler_if bus ();

  game_tick_scheduler #(
    .TICK_COUNT (10),
    .CNT_W      (4),
    .BALL_DIV   (2),
    .TIMEOUT    (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pause       (pause),
    .clr_err     (clr_err),
    .tick        (tick),
    .busy        (busy),
    .frame_cnt   (frame_cnt),
    .overrun     (overrun),
    .timeout_err (timeout_err),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [12:0] exp;
  } vec_t;

  vec_t v[15];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (k=%0d)",
                  name, act, exp, k);
  endtask

  task automatic step();
    @(negedge clk);
    k++;
  endtask

  function automatic logic sel(input int s);
    case (s)
      0:       return tick;
      1:       return bus.pad_start;
      2:       return bus.ball_start;
      3:       return bus.score_start;
      default: return busy;
    endcase
  endfunction

  task automatic wait_for(input int s, input int max,
                          input string name);
    int n = 0;
    while (!sel(s) && n < max) begin
      step();
      n++;
    end
    chk(name, 32'(sel(s)), 32'd1);
  endtask

  function automatic logic [12:0] row();
    return {tick, bus.pad_start, bus.ball_start,
            bus.score_start, busy, frame_cnt};
  endfunction

  initial begin
    #300000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int ticks;
    // k = clk edges since reset release; tick when k%10==9
    v[0]  = '{1,  {5'b00000, 8'd0}};
    v[1]  = '{9,  {5'b10000, 8'd0}};
    v[2]  = '{10, {5'b01001, 8'd0}};
    v[3]  = '{11, {5'b00101, 8'd0}};
    v[4]  = '{12, {5'b00011, 8'd0}};
    v[5]  = '{13, {5'b00000, 8'd1}};
    v[6]  = '{19, {5'b10000, 8'd1}};
    v[7]  = '{20, {5'b01001, 8'd1}};
    v[8]  = '{21, {5'b00011, 8'd1}};
    v[9]  = '{22, {5'b00000, 8'd2}};
    v[10] = '{29, {5'b10000, 8'd2}};
    v[11] = '{30, {5'b01001, 8'd2}};
    v[12] = '{31, {5'b00101, 8'd2}};
    v[13] = '{32, {5'b00011, 8'd2}};
    v[14] = '{33, {5'b00000, 8'd3}};

    reset          = 1'b0;
    pause          = 1'b0;
    clr_err        = 1'b0;
    bus.pad_done   = 1'b1;
    bus.ball_done  = 1'b1;
    bus.score_done = 1'b1;

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        32'({row(), overrun, timeout_err}), 32'd0);
    reset = 1'b1;
    k = 0;

    // 1: basic sequencing, ball every other frame
    for (int i = 0; i < 15; i++) begin
      while (k < v[i].k) step();
      chk($sformatf("vec_k%0d", v[i].k),
          32'(row()), 32'(v[i].exp));
    end
    chk("t1_no_err", 32'({overrun, timeout_err}), 32'd0);

    // 2: paddle never answers -> watchdog
    bus.pad_done = 1'b0;
    wait_for(1, 30, "t2_pad_start");
    repeat (7) step();
    chk("t2_pre_to", 32'({busy, timeout_err}), 32'b10);
    step();
    chk("t2_to", 32'({busy, timeout_err}), 32'b01);
    chk("t2_frame", 32'(frame_cnt), 32'd3);
    bus.pad_done = 1'b1;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t2_clr", 32'(timeout_err), 32'd0);
    repeat (3) step();
    chk("t2_next_seq", 32'({busy, frame_cnt}), 32'd4);

    // 3: score held so the next tick lands while busy
    bus.score_done = 1'b0;
    wait_for(2, 30, "t3_ball_start");
    step();
    chk("t3_score_start", 32'(bus.score_start), 32'd1);
    repeat (7) step();
    chk("t3_tick_busy", 32'({tick, busy}), 32'b11);
    bus.score_done = 1'b1;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t3_overrun_set_wins", 32'(overrun), 32'd1);
    chk("t3_frame", 32'(frame_cnt), 32'd5);
    chk("t3_no_queue",
        32'({busy, bus.pad_start, timeout_err}), 32'd0);
    step();
    chk("t3_idle", 32'({busy, frame_cnt}), 32'd5);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t3_clr", 32'(overrun), 32'd0);

    // 4: pause at count 5 with a sequence in flight
    bus.pad_done = 1'b0;
    wait_for(1, 30, "t4_pad_start");
    repeat (5) step();
    chk("t4_inflight", 32'(busy), 32'd1);
    pause = 1'b1;
    ticks = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (i == 0) bus.pad_done = 1'b1;
      ticks += int'(tick);
    end
    chk("t4_pause_ticks", 32'(ticks), 32'd0);
    chk("t4_completed", 32'({busy, frame_cnt}), 32'd6);
    pause = 1'b0;
    ticks = int'(tick);
    repeat (3) begin
      step();
      ticks += int'(tick);
    end
    chk("t4_early_tick", 32'(ticks), 32'd0);
    step();
    chk("t4_resume_tick", 32'(tick), 32'd1);

    // 5: asynchronous reset while waiting in BALL
    bus.ball_done = 1'b0;
    wait_for(2, 20, "t5_ball_start");
    step();
    chk("t5_in_ball", 32'({busy, frame_cnt}), 32'h106);
    #2 reset = 1'b0;
    #1 chk("t5_async_zero",
           32'({row(), overrun, timeout_err}), 32'd0);
    bus.ball_done = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    k = 0;
    ticks = 0;
    repeat (8) begin
      step();
      ticks += int'(tick);
    end
    chk("t5_no_early_tick", 32'(ticks), 32'd0);
    step();
    chk("t5_first_tick", 32'(tick), 32'd1);

    // 6: 256 sequences wrap frame_cnt
    repeat (2544) step();
    chk("t6_frame_255", 32'(frame_cnt), 32'd255);
    repeat (12) step();
    chk("t6_wrap",
        32'({busy, overrun, timeout_err, frame_cnt}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
